// File: rtl/io_serial_port.sv
`default_nettype none
// ============================================================================
// Module   : io_serial_port
// Purpose  : Serial I/O peripheral on the processor I/O lines. Every change
//            of outputLine is queued in a small TX FIFO and sent as an 18-bit
//            frame (start, 16 data bits LSB first, stop) on tx. Frames of
//            the same format received on rx update inputLine.
// Ports    : clk        - processor single-rate clock, posedge
//            rst        - synchronous reset, active low
//            outputLine - processor output word, sampled every cycle
//            inputLine  - last correctly received word
//            tx / rx    - serial lines, idle high (rx is asynchronous)
//            tx_busy    - frame in flight or FIFO non-empty
//            fifo_full  - TX FIFO holds FIFO_DEPTH entries
//            overflow   - sticky, a push was dropped
//            rx_valid   - one-cycle pulse when inputLine updates
//            frame_err  - sticky, a received frame had a bad stop bit
// Revision : 1.0 - initial release
// ============================================================================
module io_serial_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] outputLine,
    output logic [15:0] inputLine,
    output logic        tx,
    input  logic        rx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        rx_valid,
    output logic        frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] c_baud_half = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] c_baud_one  = BAUD_W'(1);
    localparam logic [PTR_W-1:0]  c_ptr_one   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(FIFO_DEPTH);
    localparam logic [4:0]        c_bit_last  = 5'd15;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Change detect and TX FIFO
    // ------------------------------------------------------------------
    logic [15:0]      prev_q;
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [15:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_empty;
    logic             full;

    tx_state_t        tx_state_q, tx_state_d;

    always_comb begin
        push_req   = (outputLine != prev_q);
        fifo_empty = (count_q == '0);
        full       = (count_q == c_cnt_full);
        // The transmitter only pops from idle, so a pop never hits an empty FIFO.
        pop        = (tx_state_q == TX_IDLE) && !fifo_empty;
        // A simultaneous pop frees the slot this push needs, even when full.
        push_ok    = push_req && (!full || pop);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_req && full && !pop);

        if (push_ok) begin
            mem_d[wr_ptr_q] = outputLine;
            wr_ptr_d        = wr_ptr_q + c_ptr_one;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= outputLine;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // TX FSM. tx is registered from the current state, so the line lags
    // the state by one cycle and never glitches.
    // ------------------------------------------------------------------
    logic [15:0]       tx_shift_q, tx_shift_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [4:0]        tx_bit_q, tx_bit_d;
    logic              tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_baud_d  = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (tx_baud_q == c_baud_last) begin
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + c_baud_one;
                end
            end
            TX_DATA: begin
                tx_d = tx_shift_q[0];
                if (tx_baud_q == c_baud_last) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[15:1]};
                    if (tx_bit_q == c_bit_last) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 5'd1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + c_baud_one;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (tx_baud_q == c_baud_last) begin
                    tx_baud_d  = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_baud_d = tx_baud_q + c_baud_one;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // RX: two-flop synchronizer followed by a mid-bit sampling FSM
    // ------------------------------------------------------------------
    logic              rx_meta_q, rx_s_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [15:0]       rx_shift_q, rx_shift_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [4:0]        rx_bit_q, rx_bit_d;
    logic [15:0]       input_line_q, input_line_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_baud_d    = rx_baud_q;
        rx_bit_d     = rx_bit_q;
        input_line_d = input_line_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = frame_err_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit,
                // anything else is a glitch and is silently ignored.
                if (rx_baud_q == c_baud_half) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + c_baud_one;
                end
            end
            RX_DATA: begin
                if (rx_baud_q == c_baud_last) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[15:1]};
                    if (rx_bit_q == c_bit_last) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 5'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + c_baud_one;
                end
            end
            RX_STOP: begin
                if (rx_baud_q == c_baud_last) begin
                    rx_baud_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s_q) begin
                        input_line_d = rx_shift_q;
                        rx_valid_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + c_baud_one;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_shift_q   <= '0;
            rx_baud_q    <= '0;
            rx_bit_q     <= '0;
            input_line_q <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_shift_q   <= rx_shift_d;
            rx_baud_q    <= rx_baud_d;
            rx_bit_q     <= rx_bit_d;
            input_line_q <= input_line_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx        = tx_q;
    assign tx_busy   = (tx_state_q != TX_IDLE) || !fifo_empty;
    assign fifo_full = full;
    assign overflow  = overflow_q;
    assign inputLine = input_line_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_serial_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_serial_port
// Purpose  : Self-checking bench for io_serial_port with CLKS_PER_BIT = 4 and
//            FIFO_DEPTH = 4. Expected TX words and RX words are queued when
//            stimulus is applied and compared when frames appear on tx or
//            rx_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_serial_port;

    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;

    logic        clk;
    logic        rst;
    logic [15:0] outputLine;
    logic [15:0] inputLine;
    logic        tx;
    logic        rx;
    logic        tx_busy;
    logic        fifo_full;
    logic        overflow;
    logic        rx_valid;
    logic        frame_err;

    io_serial_port #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .outputLine (outputLine),
        .inputLine  (inputLine),
        .tx         (tx),
        .rx         (rx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err)
    );

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          n_tx_frames;
    int          n_rx_valid;
    int          rx_valid_cyc;
    logic [15:0] tx_exp [$];
    logic [15:0] rx_exp [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, need finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [15:0] word, input logic stop_bit);
        rx = 1'b0;
        repeat (CLKS_PER_BIT) tick();
        for (int i = 0; i < 16; i++) begin
            rx = word[i];
            repeat (CLKS_PER_BIT) tick();
        end
        rx = stop_bit;
        repeat (CLKS_PER_BIT) tick();
        rx = 1'b1;
    endtask

    task automatic wait_tx_idle(input int bound, input string tag);
        int i;
        i = 0;
        while (tx_busy && i < bound) begin
            tick();
            i++;
        end
        check({tag, "_idle"}, {31'd0, tx_busy}, 32'd0);
    endtask

    task automatic wait_rx_valid(input int n0, input int bound, input string tag);
        int i;
        i = 0;
        while (n_rx_valid == n0 && i < bound) begin
            tick();
            i++;
        end
        check({tag, "_seen"}, n_rx_valid - n0, 32'd1);
    endtask

    // TX monitor: decodes frames at mid-bit, pops expected words.
    initial begin : tx_mon
        int          k;
        logic        act;
        logic [15:0] w;
        logic [15:0] e;
        act = 1'b0;
        k   = 0;
        w   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst !== 1'b1) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    k   = 0;
                end
            end else begin
                k++;
                if (k == 2) check("tx_start_bit", {31'd0, tx}, 32'd0);
                if (k >= 6 && k <= 66 && ((k - 6) % 4) == 0) w[(k - 6) / 4] = tx;
                if (k == 70) begin
                    check("tx_stop_bit", {31'd0, tx}, 32'd1);
                    check("tx_exp_avail", {31'd0, tx_exp.size() > 0}, 32'd1);
                    if (tx_exp.size() > 0) begin
                        e = tx_exp.pop_front();
                        check("tx_word", {16'd0, w}, {16'd0, e});
                    end
                    n_tx_frames++;
                    act = 1'b0;
                end
            end
        end
    end

    // RX monitor: each rx_valid pulse pops one expected word.
    initial begin : rx_mon
        logic        prev_v;
        logic [15:0] e;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rx_valid === 1'b1) begin
                n_rx_valid++;
                rx_valid_cyc = cyc;
                check("rx_valid_pulse", {31'd0, prev_v}, 32'd0);
                check("rx_exp_avail", {31'd0, rx_exp.size() > 0}, 32'd1);
                if (rx_exp.size() > 0) begin
                    e = rx_exp.pop_front();
                    check("rx_word", {16'd0, inputLine}, {16'd0, e});
                end
            end
            prev_v = (rx_valid === 1'b1);
        end
    end

    initial begin : main
        logic [15:0] vals [6];
        int          c0;
        int          n0;
        int          lat;

        n_tests      = 0;
        n_fail       = 0;
        n_tx_frames  = 0;
        n_rx_valid   = 0;
        rx_valid_cyc = 0;
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

        // 1. Reset for two cycles, then idle with outputLine held at 0
        rst        = 1'b0;
        outputLine = 16'h0000;
        rx         = 1'b1;
        tick();
        tick();
        check("rst_tx",        {31'd0, tx},        32'd1);
        check("rst_inputLine", {16'd0, inputLine}, 32'd0);
        check("rst_tx_busy",   {31'd0, tx_busy},   32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (20) tick();
        check("idle_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("idle_tx",      {31'd0, tx},      32'd1);
        check("idle_frames",  n_tx_frames,      32'd0);

        // 2. Single word, start-bit latency and full frame
        outputLine = 16'hA5C3;
        tx_exp.push_back(16'hA5C3);
        tick();
        check("push_busy",       {31'd0, tx_busy}, 32'd1);
        check("tx_high_edge_n",  {31'd0, tx},      32'd1);
        tick();
        check("tx_high_edge_n1", {31'd0, tx},      32'd1);
        tick();
        check("start_latency",   {31'd0, tx},      32'd0);
        wait_tx_idle(100, "frame1");
        repeat (3) tick();
        check("frame1_count", n_tx_frames, 32'd1);

        // 3. Six values on consecutive cycles: five fit, the sixth overflows
        for (int i = 0; i < 6; i++) begin
            outputLine = vals[i];
            if (i < 5) tx_exp.push_back(vals[i]);
            tick();
            if (i == 3) check("full_after_4", {31'd0, fifo_full}, 32'd0);
            if (i == 4) begin
                check("full_after_5",     {31'd0, fifo_full}, 32'd1);
                check("no_ovf_after_5",   {31'd0, overflow},  32'd0);
            end
            if (i == 5) begin
                check("full_after_6",     {31'd0, fifo_full}, 32'd1);
                check("ovf_after_6",      {31'd0, overflow},  32'd1);
            end
        end
        repeat (100) tick();
        check("full_drained", {31'd0, fifo_full}, 32'd0);
        wait_tx_idle(450, "burst");
        repeat (3) tick();
        check("burst_frames",    n_tx_frames,        32'd6);
        check("ovf_sticky",      {31'd0, overflow},  32'd1);
        check("tx_queue_empty1", tx_exp.size(),      32'd0);

        // 4. Good RX frame
        repeat (5) tick();
        n0 = n_rx_valid;
        c0 = cyc;
        rx_exp.push_back(16'h1234);
        send_rx(16'h1234, 1'b1);
        wait_rx_valid(n0, 20, "rx1234");
        lat = rx_valid_cyc - c0;
        check("rx_latency_ok", {31'd0, (lat >= 66 && lat <= 78)}, 32'd1);
        tick();
        check("rx_valid_low",  {31'd0, rx_valid},  32'd0);
        check("rx_inputLine",  {16'd0, inputLine}, 32'h1234);

        // 5. One-cycle glitch, then a frame with a bad stop bit
        repeat (8) tick();
        n0 = n_rx_valid;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (40) tick();
        check("glitch_no_valid", n_rx_valid,        n0);
        check("glitch_no_ferr",  {31'd0, frame_err}, 32'd0);
        send_rx(16'hFFFF, 1'b0);
        repeat (12) tick();
        check("bad_stop_ferr",   {31'd0, frame_err}, 32'd1);
        check("bad_stop_keep",   {16'd0, inputLine}, 32'h1234);
        check("bad_stop_no_vld", n_rx_valid,         n0);

        // 6. Reset mid-TX and mid-RX, then a fresh RX frame
        repeat (10) tick();
        outputLine = 16'hBEEF;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (8) tick();
        rx = 1'b0;
        repeat (8) tick();
        check("mid_frame_busy", {31'd0, tx_busy}, 32'd1);
        rst        = 1'b0;
        outputLine = 16'h0000;
        rx         = 1'b1;
        tick();
        rst = 1'b1;
        check("rst2_tx",        {31'd0, tx},        32'd1);
        check("rst2_tx_busy",   {31'd0, tx_busy},   32'd0);
        check("rst2_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst2_overflow",  {31'd0, overflow},  32'd0);
        check("rst2_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst2_inputLine", {16'd0, inputLine}, 32'd0);
        repeat (20) tick();
        check("rst2_tx_stays",  {31'd0, tx},        32'd1);
        check("rst2_no_rx",     {16'd0, inputLine}, 32'd0);
        n0 = n_rx_valid;
        rx_exp.push_back(16'h5A0F);
        send_rx(16'h5A0F, 1'b1);
        wait_rx_valid(n0, 20, "rx5a0f");
        tick();
        check("fresh_inputLine", {16'd0, inputLine}, 32'h5A0F);

        repeat (10) tick();
        check("tx_queue_empty", tx_exp.size(), 32'd0);
        check("rx_queue_empty", rx_exp.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_serial_port.md
# io_serial_port

Serial I/O peripheral on the processor's I/O lines. It consumes the processor's 16-bit `outputLine`, queues each new value, and transmits it as an 18-bit serial frame on `tx`. It also receives the same frame format on `rx` and presents the last good word as a stable `inputLine` back to the processor. Everything runs in the processor's `singleClk` domain.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Even, ≥ 4.
- `FIFO_DEPTH`, default 4: TX queue entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  processor single-rate clock; all logic on posedge.
- `rst`  in  1  reset; one clock, synchronous, active-low (asserted when 0).
- `outputLine`  in  16  processor output word, sampled every cycle.
- `inputLine`  out  16  last correctly received word, driven to the processor.
- `tx`  out  1  serial transmit line; idle high.
- `rx`  in  1  serial receive line; asynchronous, idle high.
- `tx_busy`  out  1  high while a frame is being transmitted or the FIFO is non-empty.
- `fifo_full`  out  1  TX FIFO holds `FIFO_DEPTH` entries.
- `overflow`  out  1  sticky: a push was dropped.
- `rx_valid`  out  1  one-cycle pulse when `inputLine` updates.
- `frame_err`  out  1  sticky: a received frame had a bad stop bit.

## Operation

**Change detect**
- Register `prev` holds last cycle's `outputLine`. It resets to 16'h0000 and is loaded every cycle.
- A push request occurs on any cycle where `outputLine != prev`. The pushed data is the current `outputLine`.
- Repeated identical values are never pushed.

**TX FIFO**
- Circular buffer with `FIFO_DEPTH` entries and wrap-around pointers. The count is 0..FIFO_DEPTH.
- Push while full with no pop in the same cycle: data is dropped and `overflow` is set until reset.
- Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Pop while empty cannot occur, because the transmitter only pops when the FIFO is non-empty.

**TX FSM (TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE)**
- TX_IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shift register and go to TX_START.
- TX_START: `tx` = 0 for `CLKS_PER_BIT` cycles.
- TX_DATA: 16 bits, LSB first, each held for `CLKS_PER_BIT` cycles.
- TX_STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to TX_IDLE.

**RX**
- `rx` passes through a 2-flop synchronizer, giving `rx_s`.
- RX_IDLE: on `rx_s` == 0, go to RX_START.
- RX_START: count `CLKS_PER_BIT/2` cycles, then check `rx_s`.
  - `rx_s` still 0: go to RX_DATA.
  - Otherwise: glitch, return to RX_IDLE with no flags changed.
- RX_DATA: sample `rx_s` every `CLKS_PER_BIT` cycles, 16 times, shifting LSB first.
- RX_STOP: after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - 1: `inputLine` ← shift register, pulse `rx_valid`.
  - 0: set `frame_err`; `inputLine` is unchanged.
  - Either way, return to RX_IDLE.

**Reset values**
- `tx` = 1, `inputLine` = 0, `tx_busy` = 0, `fifo_full` = 0, `overflow` = 0, `rx_valid` = 0, `frame_err` = 0.
- FIFO is emptied, both FSMs are idle, `prev` = 0.
- Reset asserted mid-frame aborts that frame immediately. `tx` is high the cycle after the reset edge. A partially received word is discarded.

## Timing

- Push latency: `outputLine` changes before edge N → entry in the FIFO after edge N.
- Start-bit latency: with the FIFO empty and TX idle, `tx` falls after edge N+2.
  - Edge N+1: pop.
  - Edge N+2: TX_START output is registered.
- Frame length: 18 × `CLKS_PER_BIT` cycles. At least one TX_IDLE cycle separates back-to-back frames.
- RX sampling: start-bit edge + 2 sync cycles + `CLKS_PER_BIT/2`, then every `CLKS_PER_BIT`.
- `rx_valid` is high for exactly one cycle, the same cycle `inputLine` first shows the new word.
- Width rules: bit counters are 5 bits, baud counter is clog2(`CLKS_PER_BIT`) bits, FIFO count is clog2(`FIFO_DEPTH`)+1 bits.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.

1. Reset with `rst` = 0 for 2 cycles → every output at its reset value and `tx` = 1. Holding `outputLine` = 0 afterwards → no frame is sent.
2. Set `outputLine` = 16'hA5C3 once → `tx` goes low 2 cycles later. The bench decodes 16'hA5C3 from a 72-cycle frame, then `tx_busy` falls.
3. Drive 6 distinct values on consecutive cycles while TX is busy with the first → first 5 are sent in order and the 6th is dropped. `overflow` = 1 and `fifo_full` toggles as expected.
4. Bench serializes 16'h1234 on `rx` with a good stop bit → `inputLine` = 16'h1234 with a single-cycle `rx_valid`, about 70 cycles after the start edge.
5. Frame 16'hFFFF with stop bit 0 → `frame_err` = 1 and `inputLine` is unchanged. A 1-cycle low glitch on `rx` → no frame and no flag.
6. Assert `rst` mid-TX-frame and mid-RX-frame → `tx` = 1 the next cycle, FIFO empty, `inputLine` = 0. A fresh frame received after reset is decoded correctly.
